// File: rtl/modulo_transferencia_rolhas.sv
// Cork transfer block: moves a requested number of corks into the main reservoir over a 4-phase req/ack handshake.
// Optional feature macro ROLHAS_CONSUMO_EN enables decrementing the reservoir on consumo pulses.
module modulo_transferencia_rolhas #(
    parameter int CAPACIDADE = 99,
    parameter int MINIMO     = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic [6:0] qtd,
    input  logic       consumo,
    output logic       ack,
    output logic       erro,
    output logic       ocupado,
    output logic [6:0] reg_principal,
    output logic       ro,
    output logic       min_signal
);

    localparam logic [7:0] CAP8 = 8'(CAPACIDADE);
    localparam logic [7:0] MIN8 = 8'(MINIMO);

    typedef enum logic [1:0] {IDLE, CHECK, TRANSFER, DONE} state_t;

    state_t     state_q, state_d;
    logic [6:0] remaining_q, remaining_d;
    logic [6:0] reg_q, reg_d;
    logic       ack_q, ack_d;
    logic       erro_q, erro_d;
    logic       ocupado_q, ocupado_d;
    logic [7:0] soma;
    logic       incremento;
    logic       consumo_ef;

`ifdef ROLHAS_CONSUMO_EN
    assign consumo_ef = consumo;
`else
    logic consumo_unused;
    assign consumo_unused = consumo;
    assign consumo_ef     = 1'b0;
`endif

    assign soma = {1'b0, reg_q} + {1'b0, remaining_q};

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ack_d       = ack_q;
        erro_d      = erro_q;
        incremento  = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d  = 1'b0;
                erro_d = 1'b0;
                if (req) begin
                    remaining_d = qtd;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (soma > CAP8) begin
                    erro_d  = 1'b1;
                    state_d = DONE;
                end else if (remaining_q == 7'd0) begin
                    erro_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (remaining_q != 7'd0) begin
                    incremento  = 1'b1;
                    remaining_d = remaining_q - 7'd1;
                end
                if (remaining_q <= 7'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // ack follows one edge after entering DONE, so both paths share the same extra cycle
                if (!req) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    erro_d  = 1'b0;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ocupado_d = (state_d != IDLE);

        // A consumo pulse in an increment cycle cancels that increment
        reg_d = reg_q;
        if (incremento && !consumo_ef) begin
            if ({1'b0, reg_q} < CAP8) begin
                reg_d = reg_q + 7'd1;
            end
        end else if (!incremento && consumo_ef && reg_q != 7'd0) begin
            reg_d = reg_q - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            remaining_q <= 7'd0;
            reg_q       <= 7'd0;
            ack_q       <= 1'b0;
            erro_q      <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reg_q       <= reg_d;
            ack_q       <= ack_d;
            erro_q      <= erro_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign ack           = ack_q;
    assign erro          = erro_q;
    assign ocupado       = ocupado_q;
    assign reg_principal = reg_q;
    assign ro            = (reg_q == 7'd0);
    assign min_signal    = ({1'b0, reg_q} < MIN8);

endmodule

// File: tb/tb_modulo_transferencia_rolhas.sv
// Self-checking bench for modulo_transferencia_rolhas: directed scenarios plus randomized requests
// checked against a count-level reservoir model.
module tb_modulo_transferencia_rolhas;

    localparam int CAP = 99;
    localparam int MIN = 15;
`ifdef ROLHAS_CONSUMO_EN
    localparam bit CONS_EN = 1'b1;
`else
    localparam bit CONS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       req;
    logic [6:0] qtd;
    logic       consumo;
    logic       ack;
    logic       erro;
    logic       ocupado;
    logic [6:0] reg_principal;
    logic       ro;
    logic       min_signal;

    int n_vec = 0;
    int n_err = 0;
    int model_reg = 0;

    modulo_transferencia_rolhas #(
        .CAPACIDADE(CAP),
        .MINIMO    (MIN)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .req          (req),
        .qtd          (qtd),
        .consumo      (consumo),
        .ack          (ack),
        .erro         (erro),
        .ocupado      (ocupado),
        .reg_principal(reg_principal),
        .ro           (ro),
        .min_signal   (min_signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_levels(input string tag);
        chk({tag, "_reg"}, 32'(reg_principal), 32'(model_reg));
        chk({tag, "_ro"}, 32'(ro), 32'(model_reg == 0));
        chk({tag, "_min"}, 32'(min_signal), 32'(model_reg < MIN));
    endtask

    // pulse_k: consumo is sampled on the k-th edge after the sampling edge (0 = no pulse)
    task automatic do_req(input int n, input int pulse_k, input string tag);
        int  lat;
        bit  accepted;
        int  exp_lat;
        int  held_reg;
        accepted = (model_reg + n <= CAP);
        exp_lat  = (accepted && n > 0) ? n + 2 : 2;
        @(negedge clk);
        qtd = 7'(n);
        req = 1'b1;
        @(posedge clk);
        #1;
        qtd = 7'($urandom);
        lat = 0;
        do begin
            consumo = (pulse_k == lat + 1);
            @(posedge clk);
            #1;
            consumo = 1'b0;
            lat++;
            if (lat == 1) chk({tag, "_ocupado_busy"}, 32'(ocupado), 32'd1);
        end while (!ack && lat < 300);
        if (accepted) begin
            model_reg += n;
            if (CONS_EN && pulse_k >= 2 && pulse_k <= n + 1) model_reg -= 1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_erro"}, 32'(erro), 32'(!accepted));
        chk_levels(tag);
        held_reg = model_reg;
        qtd = 7'($urandom);
        @(posedge clk);
        #1;
        chk({tag, "_ack_held"}, 32'(ack), 32'd1);
        chk({tag, "_held_reg"}, 32'(reg_principal), 32'(held_reg));
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_ack_release"}, 32'(ack), 32'd0);
        chk({tag, "_erro_release"}, 32'(erro), 32'd0);
        chk({tag, "_ocupado_idle"}, 32'(ocupado), 32'd0);
        $display("req qtd=%0d pulse=%0d -> latency=%0d reservoir=%0d", n, pulse_k, lat, model_reg);
    endtask

    task automatic pulse_consumo(input string tag);
        @(negedge clk);
        consumo = 1'b1;
        @(posedge clk);
        #1;
        consumo = 1'b0;
        if (CONS_EN && model_reg > 0) model_reg -= 1;
        chk_levels(tag);
        $display("consumo pulse -> reservoir=%0d", model_reg);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        req = 1'b0;
        clr = 1'b0;
        #1;
        model_reg = 0;
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
        chk_levels(tag);
        @(negedge clk);
        clr = 1'b1;
        $display("reset -> reservoir=%0d", model_reg);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr     = 1'b0;
        req     = 1'b0;
        qtd     = 7'd0;
        consumo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk_levels("rst");
        @(negedge clk);
        clr = 1'b1;

        do_req(10, 0, "q10");
        do_req(85, 0, "q85");
        do_req(5, 0, "reject5");
        do_req(4, 0, "fill4");
        do_req(0, 0, "zero_at_full");
        pulse_consumo("cons_at_full");

        reset_dut("rst2");
        pulse_consumo("cons_at_zero");

        do_req(20, 0, "q20");
        do_req(3, 3, "q3_pulse");
        pulse_consumo("cons_idle");

        // abort a transfer with reset after 12 corks have moved
        reset_dut("rst3");
        @(negedge clk);
        qtd = 7'd30;
        req = 1'b1;
        @(posedge clk);
        repeat (13) @(posedge clk);
        #1;
        chk("mid_reg12", 32'(reg_principal), 32'd12);
        chk("mid_ocupado", 32'(ocupado), 32'd1);
        #2;
        clr = 1'b0;
        req = 1'b0;
        #1;
        model_reg = 0;
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        chk_levels("abort");
        @(negedge clk);
        clr = 1'b1;
        do_req(0, 0, "zero_after_abort");

        for (int i = 0; i < 25; i++) begin
            int n;
            int pk;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 30));
            pk = 0;
            if (n > 0 && model_reg + n <= CAP && $urandom_range(0, 1) == 1)
                pk = int'($urandom_range(2, n + 1));
            do_req(n, pk, "rnd");
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) pulse_consumo("rnd_cons");
            if (i % 8 == 7) reset_dut("rnd_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modulo_transferencia_rolhas.md
MODULO_TRANSFERENCIA_ROLHAS -- requirements
Module: modulo_transferencia_rolhas

Interface
REQ-001 The block SHALL have parameter CAPACIDADE, default 99, maximum corks held in the main reservoir.
REQ-002 The block SHALL have parameter MINIMO, default 15, reservoir level below which the low-level flag is raised.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit: transfer request level from the cork-entry side (4-phase handshake).
REQ-006 The block SHALL have port qtd, input, 7 bits: corks to transfer; unsigned, sampled on request acceptance.
REQ-007 The block SHALL have port consumo, input, 1 bit: one-cycle pulse, one cork used by the sealing stage.
REQ-008 The block SHALL have port ack, output, 1 bit: request completed, either accepted or rejected.
REQ-009 The block SHALL have port erro, output, 1 bit: request rejected for capacity; valid while ack=1.
REQ-010 The block SHALL have port ocupado, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port reg_principal, output, 7 bits: current reservoir count, 0..CAPACIDADE.
REQ-012 The block SHALL have port ro, output, 1 bit: high when reg_principal==0 (combinational from the register).
REQ-013 The block SHALL have port min_signal, output, 1 bit: high when reg_principal<MINIMO (combinational from the register).

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CHECK, TRANSFER and DONE.
REQ-015 In IDLE with req=1, the block SHALL latch qtd into a 7-bit remaining counter and go to CHECK on the next edge.
REQ-016 In CHECK, if reg_principal+remaining>CAPACIDADE (8-bit sum, no wrap), the block SHALL go to DONE with erro=1 and leave the reservoir unchanged.
REQ-017 In CHECK, if remaining==0, the block SHALL go to DONE with erro=0.
REQ-018 In CHECK in all other cases, the block SHALL go to TRANSFER.
REQ-019 In TRANSFER, each cycle the block SHALL add 1 to reg_principal and subtract 1 from remaining; when remaining reaches 0 it SHALL go to DONE.
REQ-020 The latency SHALL be: a request of N>0 corks raises ack N+2 cycles after req is sampled; a rejected or zero request raises ack 2 cycles after req is sampled.
REQ-021 In DONE, ack SHALL be 1 and erro SHALL be held; the block SHALL stay in DONE until req=0, then return to IDLE with ack=0 and erro=0.
REQ-022 While ack=1, the block SHALL ignore qtd changes; a new request is accepted only in IDLE.
REQ-023 On consumo=1 with reg_principal>0 and no increment in that cycle, the block SHALL decrement reg_principal by 1.
REQ-024 On consumo=1 with reg_principal==0 and no increment, the block SHALL ignore the pulse; reg_principal stays 0 and ro stays 1.
REQ-025 On consumo=1 in a TRANSFER increment cycle, the block SHALL leave reg_principal unchanged (net zero) while remaining still decrements.
REQ-026 reg_principal SHALL never exceed CAPACIDADE and SHALL never wrap below 0.

Reset
REQ-027 While clr=0 (asynchronous), the block SHALL set state=IDLE, reg_principal=0, remaining=0, ack=0, erro=0 and ocupado=0, which gives ro=1 and min_signal=1.
REQ-028 A reset asserted during TRANSFER SHALL abort the transfer, and corks not yet moved SHALL be discarded.
REQ-029 After clr deasserts, the block SHALL accept a request on the first edge with req=1.

Configuration
REQ-030 With macro ROLHAS_CONSUMO_EN defined, consumo SHALL behave per REQ-023 to REQ-025.
REQ-031 Without ROLHAS_CONSUMO_EN, the consumo port SHALL remain present but ignored, and reg_principal SHALL change only through transfers and reset.

Verification
REQ-032 Reset, then req=1 with qtd=10 -> ack rises 12 cycles after sampling, reg_principal=10, erro=0, min_signal=1, ro=0.
REQ-033 From reg_principal=95, req with qtd=5 -> ack after 2 cycles, erro=1, reg_principal stays 95; with qtd=4 -> reg_principal=99, erro=0.
REQ-034 reg_principal=0 with a consumo pulse -> stays 0, ro=1; the same with ROLHAS_CONSUMO_EN undefined at reg_principal=20 -> stays 20.
REQ-035 Transfer of qtd=3 from reg_principal=20 with consumo pulsed in the 2nd TRANSFER cycle -> final reg_principal=22; ack held until req drops, then IDLE the next cycle.
REQ-036 clr pulsed low mid-TRANSFER (qtd=30, 12 corks moved) -> reg_principal=0, ack=0, ocupado=0 immediately; a new req with qtd=0 -> ack after 2 cycles, reg_principal=0.
